// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I opcodes, encoder format codes and output queue word type
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_LUI    = 3'd0,
        FMT_AUIPC  = 3'd1,
        FMT_JAL    = 3'd2,
        FMT_JALR   = 3'd3,
        FMT_BRANCH = 3'd4,
        FMT_OP_IMM = 3'd5,
        FMT_OP     = 3'd6
    } fmt_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } enc_word_t;

    // True when v is representable as an nbits-wide two's complement value.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned nbits);
        logic [31:0] hi;
        hi = $unsigned($signed(v) >>> (nbits - 1));
        return (hi == 32'd0) || (hi == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/rv32i_instr_encoder_if.sv
// rtl/rv32i_instr_encoder_if.sv - field input and encoded word output handshake bundle
interface rv32i_instr_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic              in_alt;
    logic [31:0]       in_imm;
    logic              addr_load;
    logic [ADDR_W-1:0] addr_base;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;

    modport master (
        output in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_alt, in_imm,
        output addr_load, addr_base, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err
    );

    modport slave (
        input  in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_alt, in_imm,
        input  addr_load, addr_base, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err
    );
endinterface

// File: rtl/rv32i_imm_pack.sv
// rtl/rv32i_imm_pack.sv - combinational fields-to-word packer; immediate range checks under RV32I_ENC_RANGE_CHECK_EN
module rv32i_imm_pack
    import rv32i_pkg::*;
(
    input  logic [2:0]  fmt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic        alt_i,
    input  logic [31:0] imm_i,
    output enc_word_t   word_o
);
    logic [31:0] raw;
    logic        legal;
    logic        range_ok;
    logic        is_shift;

    always_comb begin
        raw      = 32'd0;
        legal    = 1'b1;
        range_ok = 1'b1;
        is_shift = (funct3_i == 3'b001) || (funct3_i == 3'b101);

        case (fmt_i)
            FMT_LUI:    raw = {imm_i[31:12], rd_i, OPC_LUI};
            FMT_AUIPC:  raw = {imm_i[31:12], rd_i, OPC_AUIPC};
            FMT_JAL:    raw = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
            FMT_JALR:   raw = {imm_i[11:0], rs1_i, 3'b000, rd_i, OPC_JALR};
            FMT_BRANCH: raw = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                               imm_i[4:1], imm_i[11], OPC_BRANCH};
            FMT_OP_IMM: raw = is_shift
                            ? {1'b0, alt_i, 5'b00000, imm_i[4:0], rs1_i, funct3_i, rd_i, OPC_OP_IMM}
                            : {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_OP_IMM};
            FMT_OP:     raw = {1'b0, alt_i, 5'b00000, rs2_i, rs1_i, funct3_i, rd_i, OPC_OP};
            default:    legal = 1'b0;
        endcase

`ifdef RV32I_ENC_RANGE_CHECK_EN
        case (fmt_i)
            FMT_LUI, FMT_AUIPC: range_ok = (imm_i[11:0] == 12'd0);
            FMT_JAL:            range_ok = fits_signed(imm_i, 21) && !imm_i[0];
            FMT_JALR:           range_ok = fits_signed(imm_i, 12);
            FMT_BRANCH:         range_ok = fits_signed(imm_i, 13) && !imm_i[0]
                                           && (funct3_i[2:1] != 2'b01);
            FMT_OP_IMM:         range_ok = is_shift ? (imm_i[31:5] == 27'd0)
                                                    : fits_signed(imm_i, 12);
            default:            range_ok = 1'b1;
        endcase
`endif

        word_o.instr = (legal && range_ok) ? raw : 32'd0;
        word_o.err   = !(legal && range_ok);
    end
endmodule

// File: rtl/rv32i_instr_encoder.sv
// rtl/rv32i_instr_encoder.sv - RV32I encoder top: 2-entry output queue, address counter, handshakes
module rv32i_instr_encoder
    import rv32i_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic clk,
    input  logic rst,
    rv32i_instr_encoder_if.slave bus
);
    enc_word_t         word;
    enc_word_t         head_q, head_d, tail_q, tail_d;
    logic [ADDR_W-1:0] head_addr_q, head_addr_d, tail_addr_q, tail_addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d, entry_addr;
    logic [1:0]        count_q, count_d;
    logic              accept, pop;

    rv32i_imm_pack u_pack (
        .fmt_i    (bus.in_fmt),
        .rd_i     (bus.in_rd),
        .rs1_i    (bus.in_rs1),
        .rs2_i    (bus.in_rs2),
        .funct3_i (bus.in_funct3),
        .alt_i    (bus.in_alt),
        .imm_i    (bus.in_imm),
        .word_o   (word)
    );

    assign bus.in_ready  = (count_q != 2'd2);
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_instr = head_q.instr;
    assign bus.out_err   = head_q.err;
    assign bus.out_addr  = head_addr_q;

    assign accept     = bus.in_valid && bus.in_ready;
    assign pop        = bus.out_valid && bus.out_ready;
    assign entry_addr = bus.addr_load ? bus.addr_base : cnt_q;

    // The head slot is the output register; the tail shifts into it on pop.
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        head_addr_d = head_addr_q;
        tail_addr_d = tail_addr_q;
        if (pop) begin
            head_d      = tail_q;
            head_addr_d = tail_addr_q;
        end
        if (accept) begin
            if ((count_q == 2'd0) || (pop && (count_q == 2'd1))) begin
                head_d      = word;
                head_addr_d = entry_addr;
            end else begin
                tail_d      = word;
                tail_addr_d = entry_addr;
            end
        end
        count_d = count_q + {1'b0, accept} - {1'b0, pop};
        if (accept) begin
            cnt_d = entry_addr + ADDR_W'(4);
        end else if (bus.addr_load) begin
            cnt_d = bus.addr_base;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            head_addr_q <= RESET_ADDR;
            tail_addr_q <= RESET_ADDR;
            count_q     <= 2'd0;
            cnt_q       <= RESET_ADDR;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            head_addr_q <= head_addr_d;
            tail_addr_q <= tail_addr_d;
            count_q     <= count_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// tb/tb_rv32i_instr_encoder.sv - scoreboard bench for rv32i_instr_encoder with directed vectors
module tb_rv32i_instr_encoder;
    import rv32i_pkg::*;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } exp_t;

`ifdef RV32I_ENC_RANGE_CHECK_EN
    localparam logic [31:0] EXP_B7     = 32'h0000_0000;
    localparam logic        EXP_B7_ERR = 1'b1;
    localparam logic [31:0] EXP_BIG     = 32'h0000_0000;
    localparam logic        EXP_BIG_ERR = 1'b1;
`else
    localparam logic [31:0] EXP_B7     = 32'h0020_8363;
    localparam logic        EXP_B7_ERR = 1'b0;
    localparam logic [31:0] EXP_BIG     = 32'h0000_0093;
    localparam logic        EXP_BIG_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    exp_t        exp_q[$];
    logic [31:0] model_addr = 32'd0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        hold_v = 1'b0;
    logic [31:0] hold_instr, hold_addr;

    rv32i_instr_encoder_if #(.ADDR_W(32)) bus ();

    rv32i_instr_encoder #(.ADDR_W(32), .RESET_ADDR(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                        input logic [31:0] imm, input logic [31:0] exp_instr, input logic exp_err,
                        input logic ld = 1'b0, input logic [31:0] base = 32'd0);
        exp_t e;
        int   n = 0;
        bus.in_fmt = fmt; bus.in_rd = rd; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
        bus.in_funct3 = f3; bus.in_alt = alt; bus.in_imm = imm;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        end else begin
            e.addr      = ld ? base : model_addr;
            e.instr     = exp_instr;
            e.err       = exp_err;
            model_addr  = e.addr + 32'd4;
            exp_q.push_back(e);
            bus.addr_load = ld;
            bus.addr_base = base;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.addr_load = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        exp_q.delete();
        model_addr = 32'd0;
        rst = 1'b1;
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks hold stability.
    always @(negedge clk) begin
        if (rst) begin
            hold_v <= 1'b0;
        end else begin
            if (hold_v && bus.out_valid) begin
                chk("hold_instr", bus.out_instr, hold_instr);
                chk("hold_addr", bus.out_addr, hold_addr);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", bus.out_instr, 32'hxxxx_xxxx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_instr", bus.out_instr, e.instr);
                    chk("out_addr", bus.out_addr, e.addr);
                    chk("out_err", 32'(bus.out_err), 32'(e.err));
                end
            end
            hold_v     <= bus.out_valid && !bus.out_ready;
            hold_instr <= bus.out_instr;
            hold_addr  <= bus.out_addr;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_fmt = 3'd0; bus.in_rd = 5'd0; bus.in_rs1 = 5'd0;
        bus.in_rs2 = 5'd0; bus.in_funct3 = 3'd0; bus.in_alt = 1'b0; bus.in_imm = 32'd0;
        bus.addr_load = 1'b0; bus.addr_base = 32'd0; bus.out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_out_instr", bus.out_instr, 32'd0);
        chk("reset_out_addr", bus.out_addr, 32'd0);
        chk("reset_out_err", 32'(bus.out_err), 32'd0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

        bus.out_ready = 1'b1;
        send(FMT_OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5, 32'h0050_0093, 1'b0);
        chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
        drain();

        do_reset();
        bus.out_ready = 1'b1;
        send(FMT_LUI, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 32'h1234_5000, 32'h1234_5137, 1'b0);
        send(FMT_OP, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 32'd0, 32'h4020_81B3, 1'b0);
        send(FMT_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd8, 32'h0020_8463, 1'b0);
        send(FMT_JAL, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2048, 32'h0010_00EF, 1'b0);
        send(FMT_JALR, 5'd0, 5'd1, 5'd0, 3'b000, 1'b0, 32'd0, 32'h0000_8067, 1'b0);
        send(FMT_OP_IMM, 5'd5, 5'd6, 5'd0, 3'b101, 1'b1, 32'd3, 32'h4033_5293, 1'b0);
        send(FMT_AUIPC, 5'd10, 5'd0, 5'd0, 3'b000, 1'b0, 32'hFFFF_F000, 32'hFFFF_F517, 1'b0);
        send(FMT_BRANCH, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
        send(FMT_BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd7, EXP_B7, EXP_B7_ERR);
        send(FMT_OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd4096, EXP_BIG, EXP_BIG_ERR);
        send(3'd7, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 32'd0, 32'h0000_0000, 1'b1);

        send(FMT_OP, 5'd4, 5'd4, 5'd4, 3'b111, 1'b0, 32'd0, 32'h0042_7233, 1'b0,
             1'b1, 32'h0000_0100);
        send(FMT_OP, 5'd4, 5'd4, 5'd4, 3'b110, 1'b0, 32'd0, 32'h0042_6233, 1'b0);
        bus.addr_load = 1'b1;
        bus.addr_base = 32'h0000_0200;
        tick();
        bus.addr_load = 1'b0;
        model_addr = 32'h0000_0200;
        send(FMT_OP, 5'd4, 5'd4, 5'd4, 3'b100, 1'b0, 32'd0, 32'h0042_4233, 1'b0);
        send(FMT_LUI, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'h0000_1000, 32'h0000_10B7, 1'b0,
             1'b1, 32'hFFFF_FFFC);
        send(FMT_LUI, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'h0000_2000, 32'h0000_20B7, 1'b0);
        drain();

        do_reset();
        bus.out_ready = 1'b0;
        send(FMT_OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5, 32'h0050_0093, 1'b0);
        send(FMT_LUI, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 32'h1234_5000, 32'h1234_5137, 1'b0);
        chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        fork
            send(FMT_OP, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 32'd0, 32'h4020_81B3, 1'b0);
            begin
                for (int i = 0; i < 3; i++) begin
                    tick();
                    chk("bp_in_ready_held", 32'(bus.in_ready), 32'd0);
                    chk("bp_out_instr_held", bus.out_instr, 32'h0050_0093);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        bus.out_ready = 1'b0;
        send(FMT_JALR, 5'd0, 5'd1, 5'd0, 3'b000, 1'b0, 32'd0, 32'h0000_8067, 1'b0);
        send(FMT_JALR, 5'd0, 5'd1, 5'd0, 3'b000, 1'b0, 32'd0, 32'h0000_8067, 1'b0);
        do_reset();
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_out_addr", bus.out_addr, 32'd0);
        bus.out_ready = 1'b1;
        send(FMT_OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5, 32'h0050_0093, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rv32i_instr_encoder.md
Name: rv32i_instr_encoder

Overview:
Inverse of the instruction decoder. It accepts decoded instruction fields (format, registers, funct3, alt bit, immediate) over a valid/ready handshake and packs them into 32-bit RV32I instruction words. It buffers the words in a 2-entry output queue and tags each word with an instruction-memory byte address. It sits between the test-program generator / loader and instruction memory.

Parameters:
ADDR_W, 32, width of the instruction-memory byte address counter.
RESET_ADDR, 32'h0000_0000, address counter value after reset.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  input fields valid.
in_ready  out  1  encoder can accept fields this cycle.
in_fmt  in  3  format code, from package enum: LUI, AUIPC, JAL, JALR, BRANCH, OP_IMM, OP; codes 7 and up are illegal.
in_rd  in  5  destination register.
in_rs1  in  5  source register 1.
in_rs2  in  5  source register 2.
in_funct3  in  3  funct3 field.
in_alt  in  1  alternate op (SUB/SRA/SRAI), placed into bit 30.
in_imm  in  32  full signed immediate, byte offset for JAL/BRANCH.
addr_load  in  1  load address counter from addr_base.
addr_base  in  ADDR_W  new base address; must be word aligned.
out_valid  out  1  encoded word available.
out_ready  in  1  consumer takes word.
out_instr  out  32  encoded instruction word.
out_addr  out  ADDR_W  byte address for out_instr.
out_err  out  1  word failed encoding checks.

Behaviour:
- Reset values: out_valid=0, out_instr=0, out_addr=RESET_ADDR, out_err=0. Queue empty, counter=RESET_ADDR, in_ready=1 in the cycle after reset.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Output pop = out_valid & out_ready.
  - out_* are held stable while out_valid=1 and out_ready=0.
- Queue:
  - 2 entries, each holding {instr, addr, err}.
  - in_ready = (count<2), registered-equivalent; it does not depend on out_ready in the same cycle.
  - Push and pop in the same cycle leave count unchanged.
- Latency: a word accepted in cycle N appears on out_* in cycle N+1 when the queue was empty. Throughput is 1 word/cycle while the consumer keeps out_ready=1.
- Address counter:
  - On accept, the entry takes the current counter value and the counter becomes counter+4 modulo 2^ADDR_W (wraps silently).
  - If addr_load and an accept occur in the same cycle, the entry takes addr_base and the counter becomes addr_base+4.
  - addr_load alone sets the counter to addr_base; entries already queued keep their addresses.
- Packing, with bits listed MSB..LSB:
  - LUI: imm[31:12], rd, 0110111.
  - AUIPC: imm[31:12], rd, 0010111.
  - JAL: imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111.
  - JALR: imm[11:0], rs1, 000, rd, 1100111.
  - BRANCH: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011.
  - OP_IMM: funct3 001/101 → 0, alt, 00000, imm[4:0], rs1, funct3, rd, 0010011; all other funct3 → imm[11:0], rs1, funct3, rd, 0010011.
  - OP: 0, alt, 00000, rs2, rs1, funct3, rd, 0110011.
- Errors: an illegal in_fmt is still accepted; it produces out_instr=0, out_err=1 and consumes an address.
- Reset mid-operation: queued words are discarded, the counter returns to RESET_ADDR, and no out_valid is asserted in the cycle after rst.

Optional Feature:
RV32I_ENC_RANGE_CHECK_EN.
- Defined: the immediate is range checked. Any violation gives out_instr=0, out_err=1 and still consumes an address. Rules:
  - JALR and OP_IMM: imm must lie in [-2048, 2047].
  - Shifts: imm[31:5] must be 0.
  - BRANCH: imm must lie in [-4096, 4094] and be even.
  - JAL: imm must lie in [-2^20, 2^20-2] and be even.
  - LUI/AUIPC: imm[11:0] must be 0.
  - BRANCH: funct3 010/011 is illegal.
- Undefined: no checks; the immediate is silently truncated. out_err is set only for an illegal in_fmt.

Decomposition:
- Package rv32i_pkg holds:
  - the opcode localparams: OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_OP_IMM, OPC_OP;
  - the fmt_t enum (3 bits);
  - the queue entry struct.
- Sub-module rv32i_imm_pack: combinational fields→word packer plus the range-check logic.
- The top level holds the queue, the address counter and the handshake logic.

Test Plan:
- OP_IMM rd=1, rs1=0, funct3=000, imm=5 → out_instr=0x00500093, out_addr=0x0, next cycle.
- LUI rd=2, imm=0x12345000, then OP rd=3, rs1=1, rs2=2, alt=1 (SUB) → 0x12345137 @0x0, then 0x402081B3 @0x4.
- BRANCH rs1=1, rs2=2, funct3=000, imm=8 → 0x00208463. JAL rd=1, imm=2048 → 0x001000EF. JALR rd=0, rs1=1, imm=0 → 0x00008067.
- Backpressure with out_ready=0 and 3 inputs offered → in_ready drops after 2 accepts, outputs stay stable. Release out_ready → words appear in order at 0x0, 0x4, 0x8 with none lost.
- addr_load with addr_base=0x100 in the same cycle as an accept → word @0x100, next word @0x104. With ADDR_W=4 and the counter at 0xC, the following word is @0x0.
- With RV32I_ENC_RANGE_CHECK_EN: BRANCH imm=7 or OP_IMM imm=4096 → out_instr=0, out_err=1. Without the macro, the same OP_IMM gives 0x00000093 with out_err=0. in_fmt=7 → out_err=1 in both builds. Assert rst with 2 entries queued → out_valid=0 next cycle.
